// File: rtl/pipe_stage_regs_pkg.sv
// Shared constants for the pipeline-register slice.
//   XLEN_DEF   : default instruction / PC width
//   CTRL_W_DEF : default width of the decoded control bundle carried ID->WB
//   CNT_W_DEF  : default width of the performance counters
//   NOP_INSTR  : instruction word placed in IF/ID on a flush
//   RST_PC     : PC value placed in IF/ID on reset or flush
//   RST_VALID  : valid bit value of an empty stage
package pipe_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RST_PC    = 32'h0000_0000;
  localparam logic        RST_VALID = 1'b0;

endpackage

// File: rtl/pipe_stage_regs_stage_reg.sv
// Payload + valid pipeline register with kill and hold.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   kill      : load an empty entry (valid=0, payload=0); wins over hold
//   hold      : keep the current contents
//   in_valid  : valid bit of the incoming entry
//   in_data   : payload of the incoming entry
//   out_valid : registered valid bit
//   out_data  : registered payload, always 0 when out_valid is 0
module stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned W = CTRL_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kill,
  input  logic         hold,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (!rst_n || kill) begin
      out_valid <= RST_VALID;
      out_data  <= '0;
    end else if (!hold) begin
      out_valid <= in_valid;
      // An invalid entry carries a zero payload so no write-enables leak downstream.
      out_data  <= in_valid ? in_data : '0;
    end
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// Pipeline registers of the 5-stage MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries out the flush/kill/hold decisions of the hazard unit on the clock
// edge and keeps retirement / bubble counters.
//   clk, rst_n                : clock, synchronous active-low reset
//   if_instr, if_pc           : fetched instruction and its PC+4
//   id_ctrl                   : control bundle decoded from id_instr
//   if_id_flush               : discard IF/ID contents (redirect)
//   id_ex_kill, ex_mem_kill   : squash the entry entering ID/EX, EX/MEM
//   load_hold                 : freeze PC and IF/ID, bubble into ID/EX
//   id_instr, id_pc           : IF/ID contents
//   id/ex/mem/wb_valid        : per-stage valid bits
//   ex/mem/wb_ctrl            : per-stage control bundles
//   pc_write_en               : PC register enable (combinational)
//   retired_cnt, bubble_cnt   : wrapping performance counters
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              if_id_flush,
  input  logic              id_ex_kill,
  input  logic              ex_mem_kill,
  input  logic              load_hold,
  output logic [XLEN-1:0]   id_instr,
  output logic [XLEN-1:0]   id_pc,
  output logic              id_valid,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic              pc_write_en,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic id_ex_bubble;
  logic bubble_evt;

  // A flush overrides a hold so the redirect target is always written.
  assign pc_write_en  = if_id_flush | ~load_hold;
  assign id_ex_bubble = id_ex_kill | load_hold;
  assign bubble_evt   = id_valid & id_ex_bubble;

  // IF/ID
  always_ff @(posedge clk) begin
    if (!rst_n || if_id_flush) begin
      id_instr <= XLEN'(NOP_INSTR);
      id_pc    <= XLEN'(RST_PC);
      id_valid <= RST_VALID;
    end else if (!load_hold) begin
      id_instr <= if_instr;
      id_pc    <= if_pc;
      id_valid <= 1'b1;
    end
  end

  stage_reg #(.W(CTRL_W)) u_id_ex (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (id_ex_bubble),
    .hold      (1'b0),
    .in_valid  (id_valid),
    .in_data   (id_ctrl),
    .out_valid (ex_valid),
    .out_data  (ex_ctrl)
  );

  stage_reg #(.W(CTRL_W)) u_ex_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (ex_mem_kill),
    .hold      (1'b0),
    .in_valid  (ex_valid),
    .in_data   (ex_ctrl),
    .out_valid (mem_valid),
    .out_data  (mem_ctrl)
  );

  stage_reg #(.W(CTRL_W)) u_mem_wb (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (1'b0),
    .hold      (1'b0),
    .in_valid  (mem_valid),
    .in_data   (mem_ctrl),
    .out_valid (wb_valid),
    .out_data  (wb_ctrl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (wb_valid)   retired_cnt <= retired_cnt + CNT_W'(1);
      if (bubble_evt) bubble_cnt  <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Self-checking bench for pipe_stage_regs: a reference model produces the
// expected post-edge state, which is queued when stimulus is driven and
// popped for comparison after the edge; directed checks cover the scenarios.
module tb_pipe_stage_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic [7:0]  id_ctrl = '0;
  logic        if_id_flush = 1'b0;
  logic        id_ex_kill = 1'b0;
  logic        ex_mem_kill = 1'b0;
  logic        load_hold = 1'b0;

  logic [31:0] d_id_instr, d_id_pc;
  logic        d_id_v, d_ex_v, d_mem_v, d_wb_v, d_pcwe;
  logic [7:0]  d_ex_c, d_mem_c, d_wb_c;
  logic [31:0] d_ret, d_bub;

  logic [31:0] r4_id_instr, r4_id_pc;
  logic        r4_id_v, r4_ex_v, r4_mem_v, r4_wb_v, r4_pcwe;
  logic [7:0]  r4_ex_c, r4_mem_c, r4_wb_c;
  logic [3:0]  r4_ret, r4_bub;

  always #5 clk = ~clk;

  pipe_stage_regs #(.XLEN(32), .CTRL_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc(if_pc), .id_ctrl(id_ctrl),
    .if_id_flush(if_id_flush), .id_ex_kill(id_ex_kill), .ex_mem_kill(ex_mem_kill),
    .load_hold(load_hold), .id_instr(d_id_instr), .id_pc(d_id_pc), .id_valid(d_id_v),
    .ex_valid(d_ex_v), .mem_valid(d_mem_v), .wb_valid(d_wb_v), .ex_ctrl(d_ex_c),
    .mem_ctrl(d_mem_c), .wb_ctrl(d_wb_c), .pc_write_en(d_pcwe),
    .retired_cnt(d_ret), .bubble_cnt(d_bub)
  );

  pipe_stage_regs #(.XLEN(32), .CTRL_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc(if_pc), .id_ctrl(id_ctrl),
    .if_id_flush(if_id_flush), .id_ex_kill(id_ex_kill), .ex_mem_kill(ex_mem_kill),
    .load_hold(load_hold), .id_instr(r4_id_instr), .id_pc(r4_id_pc), .id_valid(r4_id_v),
    .ex_valid(r4_ex_v), .mem_valid(r4_mem_v), .wb_valid(r4_wb_v), .ex_ctrl(r4_ex_c),
    .mem_ctrl(r4_mem_c), .wb_ctrl(r4_wb_c), .pc_write_en(r4_pcwe),
    .retired_cnt(r4_ret), .bubble_cnt(r4_bub)
  );

  typedef struct {
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_v, ex_v, mem_v, wb_v;
    logic [7:0]  ex_c, mem_c, wb_c;
    logic [31:0] ret, bub;
  } st_t;

  st_t         m;
  st_t         sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [31:0] pc_ctr = 32'h0040_0004;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference behaviour of one clock edge.
  function automatic st_t next_st(input st_t s, input logic rst, input logic fl,
                                  input logic kx, input logic km, input logic hd,
                                  input logic [31:0] instr, input logic [31:0] pc,
                                  input logic [7:0] ctrl);
    st_t n;
    n = s;
    if (!rst) begin
      n = '{default: '0};
    end else begin
      n.ret = s.ret + (s.wb_v ? 32'd1 : 32'd0);
      n.bub = s.bub + ((s.id_v && (kx || hd)) ? 32'd1 : 32'd0);
      n.wb_v = s.mem_v;
      n.wb_c = s.mem_c;
      n.mem_v = km ? 1'b0 : s.ex_v;
      n.mem_c = km ? 8'h00 : s.ex_c;
      n.ex_v = (kx || hd) ? 1'b0 : s.id_v;
      n.ex_c = (kx || hd || !s.id_v) ? 8'h00 : ctrl;
      if (fl) begin
        n.id_instr = '0; n.id_pc = '0; n.id_v = 1'b0;
      end else if (!hd) begin
        n.id_instr = instr; n.id_pc = pc; n.id_v = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic step(input logic rst, input logic [31:0] instr, input logic fl,
                      input logic kx, input logic km, input logic hd);
    st_t e;
    rst_n = rst; if_instr = instr; if_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4;
    id_ctrl = m.id_instr[7:0] ^ 8'h3C;
    if_id_flush = fl; id_ex_kill = kx; ex_mem_kill = km; load_hold = hd;
    #1;
    chk("pc_write_en", {31'd0, d_pcwe}, {31'd0, fl | ~hd});
    chk("pc_write_en4", {31'd0, r4_pcwe}, {31'd0, fl | ~hd});
    m = next_st(m, rst, fl, kx, km, hd, instr, if_pc, id_ctrl);
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("id_instr", d_id_instr, e.id_instr);
    chk("id_pc", d_id_pc, e.id_pc);
    chk("id_valid", {31'd0, d_id_v}, {31'd0, e.id_v});
    chk("ex_valid", {31'd0, d_ex_v}, {31'd0, e.ex_v});
    chk("mem_valid", {31'd0, d_mem_v}, {31'd0, e.mem_v});
    chk("wb_valid", {31'd0, d_wb_v}, {31'd0, e.wb_v});
    chk("ex_ctrl", {24'd0, d_ex_c}, {24'd0, e.ex_c});
    chk("mem_ctrl", {24'd0, d_mem_c}, {24'd0, e.mem_c});
    chk("wb_ctrl", {24'd0, d_wb_c}, {24'd0, e.wb_c});
    chk("retired_cnt", d_ret, e.ret);
    chk("bubble_cnt", d_bub, e.bub);
    chk("retired_cnt4", {28'd0, r4_ret}, {28'd0, e.ret[3:0]});
    chk("bubble_cnt4", {28'd0, r4_bub}, {28'd0, e.bub[3:0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] b0;
    m = '{default: '0};

    // Reset held over several edges while inputs toggle.
    step(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_id_valid", {31'd0, d_id_v}, 32'd0);
    chk("rst_retired", d_ret, 32'd0);
    chk("rst_bubble", d_bub, 32'd0);

    // Four instructions, then flush IF so nothing further enters.
    step(1'b1, 32'h2001_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2002_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2003_0003, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_wb_not_yet", {31'd0, d_wb_v}, 32'd0);
    step(1'b1, 32'h2004_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_wb_rise", {31'd0, d_wb_v}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("retired_after_8", d_ret, 32'd4);

    // Jump: flush while IF/ID holds 0x8C010004.
    step(1'b1, 32'h0000_0A0A, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jump_pre_id", d_id_instr, 32'h8C01_0004);
    step(1'b1, 32'h0000_0B0B, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("jump_id_instr", d_id_instr, 32'd0);
    chk("jump_id_valid", {31'd0, d_id_v}, 32'd0);
    chk("jump_ex_adv", {31'd0, d_ex_v}, 32'd1);
    chk("jump_mem_adv", {31'd0, d_mem_v}, 32'd1);

    // Branch: all three kills with ID, EX and MEM valid.
    step(1'b1, 32'h0000_1C01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_1C02, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_1C03, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_1C04, 1'b0, 1'b0, 1'b0, 1'b0);
    b0 = m.bub;
    step(1'b1, 32'h0000_1C05, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("br_ex_valid", {31'd0, d_ex_v}, 32'd0);
    chk("br_ex_ctrl", {24'd0, d_ex_c}, 32'd0);
    chk("br_mem_valid", {31'd0, d_mem_v}, 32'd0);
    chk("br_mem_ctrl", {24'd0, d_mem_c}, 32'd0);
    chk("br_wb_valid", {31'd0, d_wb_v}, 32'd1);
    chk("br_bubble", d_bub, b0 + 32'd1);

    // Load-use hold for one edge.
    step(1'b1, 32'h0021_1010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0022_1820, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0023_2030, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold_id_instr", d_id_instr, 32'h0022_1820);
    chk("hold_ex_valid", {31'd0, d_ex_v}, 32'd0);
    step(1'b1, 32'h0023_2030, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_ex_reenter", {31'd0, d_ex_v}, 32'd1);
    chk("hold_ex_ctrl", {24'd0, d_ex_c}, 32'h0000_001C);
    chk("hold_id_next", d_id_instr, 32'h0023_2030);

    // Flush and hold together.
    step(1'b1, 32'h0031_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0031_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fh_id_valid", {31'd0, d_id_v}, 32'd0);
    chk("fh_id_instr", d_id_instr, 32'd0);
    chk("fh_ex_valid", {31'd0, d_ex_v}, 32'd0);

    // Random mix of kills/holds.
    for (int i = 0; i < 40; i++)
      step(1'b1, $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));

    // Mid-operation reset, then 16 retirements wrap the 4-bit counter.
    step(1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_wb_valid", {31'd0, d_wb_v}, 32'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 32'h0100_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_ret32", d_ret, 32'd16);
    chk("wrap_ret4", {28'd0, r4_ret}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
